// File: rtl/multibyte_tx_pkg.sv
// rtl/multibyte_tx_pkg.sv - shared types and helpers for the multi-byte result transmitter
package multibyte_tx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        CHECK,
        DONE
    } state_t;

    // A zero or out-of-range request means "send the whole word".
    function automatic int eff_count(input int count, input int max_bytes);
        return ((count == 0) || (count > max_bytes)) ? max_bytes : count;
    endfunction

endpackage

// File: rtl/delay_counter.sv
// rtl/delay_counter.sv - reloadable countdown; expired during the last counted cycle
module delay_counter #(
    parameter int MAX = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [$clog2(MAX+1)-1:0]   value,
    output logic                       expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // A value of 0 behaves like 1: the owner leaves after a single cycle.
    assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/multibyte_tx_ctrl.sv
// rtl/multibyte_tx_ctrl.sv - latches an N-byte result and feeds it byte-wise to a UART TX; optional XOR trailer under MULTIBYTE_TX_CTRL_CHECKSUM_EN
module multibyte_tx_ctrl
    import multibyte_tx_pkg::*;
#(
    parameter int NUM_BYTES               = 4,
    parameter int INTER_BYTE_DELAY        = 1_000_000,
    parameter int WAIT_FOR_REGISTER_DELAY = 100
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(NUM_BYTES+1)-1:0]  byte_count,
    input  logic                            msb_first,
    input  logic [BYTE_W*NUM_BYTES-1:0]     data_in,
    input  logic                            tx_busy,
    output logic                            tx_start,
    output logic [BYTE_W-1:0]               tx_data,
    output logic                            tx_sent,
    output logic                            busy,
    output logic [BYTE_W*NUM_BYTES-1:0]     disp_data,
    output logic                            disp_en
);

    localparam int DATA_W  = BYTE_W * NUM_BYTES;
    localparam int CW      = $clog2(NUM_BYTES + 1);
    localparam int KW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WFR_EFF = (WAIT_FOR_REGISTER_DELAY < 1) ? 1 : WAIT_FOR_REGISTER_DELAY;
    localparam int DLY_MAX = (INTER_BYTE_DELAY > WFR_EFF) ? INTER_BYTE_DELAY : WFR_EFF;
    localparam int DW      = $clog2(DLY_MAX + 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q;
    logic [CW-1:0]       n_q;
    logic                msb_q;
    logic [KW-1:0]       k_q, k_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   disp_q;
    logic                disp_en_q;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
    logic                chk_q, chk_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
`endif

    logic                accept;
    logic                last_byte;
    logic                dly_load;
    logic [DW-1:0]       dly_value;
    logic                dly_expired;
    int                  cur_idx;
    logic [BYTE_W-1:0]   cur_byte;
    int                  eff_n;
    logic [DATA_W-1:0]   disp_new;

    assign accept    = (state_q == IDLE) && start;
    assign last_byte = (int'(k_q) == (int'(n_q) - 1));

    delay_counter #(
        .MAX (DLY_MAX)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .load    (dly_load),
        .value   (dly_value),
        .expired (dly_expired)
    );

    // Byte to send next: k counts send order, the index walks down when msb_first.
    always_comb begin
        cur_idx  = msb_q ? (int'(n_q) - 1 - int'(k_q)) : int'(k_q);
        cur_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i == cur_idx) begin
                cur_byte = data_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Display copy only shows the bytes that will actually go out.
    always_comb begin
        eff_n    = eff_count(int'(byte_count), NUM_BYTES);
        disp_new = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i < eff_n) begin
                disp_new[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tx_data_d = tx_data_q;
        dly_load  = 1'b0;
        dly_value = DW'(INTER_BYTE_DELAY);
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
        chk_d     = chk_q;
        xor_d     = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LATCH;
                    dly_load  = 1'b1;
                    dly_value = DW'(WFR_EFF);
                    k_d       = '0;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
                    chk_d     = 1'b0;
                    xor_d     = '0;
`endif
                end
            end
            LATCH: begin
                if (dly_expired) begin
                    state_d   = START;
                    tx_data_d = cur_byte;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
                    xor_d     = xor_q ^ cur_byte;
`endif
                end
            end
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
                    if (chk_q) begin
                        state_d = DONE;
                    end else if (last_byte) begin
                        state_d  = GAP;
                        dly_load = 1'b1;
                        chk_d    = 1'b1;
                    end else begin
                        state_d  = GAP;
                        dly_load = 1'b1;
                        k_d      = k_q + KW'(1);
                    end
`else
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        state_d  = GAP;
                        dly_load = 1'b1;
                        k_d      = k_q + KW'(1);
                    end
`endif
                end
            end
            GAP: begin
                if (dly_expired) begin
                    state_d   = START;
                    tx_data_d = cur_byte;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
                    xor_d     = xor_q ^ cur_byte;
                    if (chk_q) begin
                        state_d   = CHECK;
                        tx_data_d = xor_q;
                    end
`endif
                end
            end
            CHECK: state_d = WAIT_BUSY;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            n_q       <= '0;
            msb_q     <= 1'b0;
            k_q       <= '0;
            tx_data_q <= '0;
            disp_q    <= '0;
            disp_en_q <= 1'b0;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
            chk_q     <= 1'b0;
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tx_data_q <= tx_data_d;
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
            chk_q     <= chk_d;
            xor_q     <= xor_d;
`endif
            if (accept) begin
                data_q    <= data_in;
                n_q       <= CW'(eff_n);
                msb_q     <= msb_first;
                disp_q    <= disp_new;
                disp_en_q <= 1'b1;
            end
        end
    end

    assign tx_start  = (state_q == START) || (state_q == CHECK);
    assign tx_data   = tx_data_q;
    assign tx_sent   = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign disp_data = disp_q;
    assign disp_en   = disp_en_q;

endmodule

// File: tb/tb_multibyte_tx_ctrl.sv
// tb/tb_multibyte_tx_ctrl.sv - randomized self-checking bench with a 10-cycle UART busy model
module tb_multibyte_tx_ctrl;

    localparam int NB        = 4;
    localparam int IBD       = 5;
    localparam int WFR       = 3;
    localparam int UART_BUSY = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  byte_count;
    logic        msb_first;
    logic [31:0] data_in;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_sent;
    logic        busy;
    logic [31:0] disp_data;
    logic        disp_en;

    int tests = 0;
    int fails = 0;
    int ncyc = 0;
    int busy_cnt = 0;
    int sent_cnt = 0;

    int         start_cycs[$];
    logic [7:0] got[$];
    int         falls[$];
    logic [7:0] exp_q[$];
    logic [31:0] exp_disp;

    multibyte_tx_ctrl #(
        .NUM_BYTES               (NB),
        .INTER_BYTE_DELAY        (IBD),
        .WAIT_FOR_REGISTER_DELAY (WFR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .msb_first  (msb_first),
        .data_in    (data_in),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_sent    (tx_sent),
        .busy       (busy),
        .disp_data  (disp_data),
        .disp_en    (disp_en)
    );

    always #5 clk = ~clk;

    // UART model and monitor, both working on the falling edge.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (tx_start) begin
            got.push_back(tx_data);
            start_cycs.push_back(ncyc + 1);
            busy_cnt <= UART_BUSY;
            tx_busy  <= 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                tx_busy <= 1'b0;
                falls.push_back(ncyc + 1);
            end
        end
        if (tx_sent) sent_cnt <= sent_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] d, input int bc, input bit msb);
        int         n;
        logic [7:0] x;
        logic [7:0] tmp[$];
        n = (bc == 0 || bc > NB) ? NB : bc;
        tmp.delete();
        for (int i = 0; i < n; i++) tmp.push_back(8'((d >> (8 * i)) & 32'hFF));
        if (msb) tmp.reverse();
        exp_q = tmp;
        x = 8'h00;
        foreach (tmp[i]) x = x ^ tmp[i];
`ifdef MULTIBYTE_TX_CTRL_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_disp = 32'(({32'h0, d}) & ((64'h1 << (8 * n)) - 64'h1));
    endtask

    task automatic wait_uart_idle();
        int guard;
        guard = 0;
        while (tx_busy && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
    endtask

    task automatic run_frame(input logic [31:0] d, input int bc, input bit msb, input bit poke);
        int m;
        int s0;
        bit seen;
        bit poked;
        wait_uart_idle();
        build_exp(d, bc, msb);
        got.delete(); start_cycs.delete(); falls.delete();
        s0 = sent_cnt;
        @(negedge clk); #1;
        data_in = d; byte_count = 3'(bc); msb_first = msb; start = 1'b1;
        m = ncyc;
        @(negedge clk); #1;
        start = 1'b0; data_in = $urandom; byte_count = 3'($urandom_range(0, 7)); msb_first = ~msb;
        chk("busy_after_start", 64'(busy), 64'd1);
        seen = 1'b0; poked = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            start = poke && !poked && (start_cycs.size() == 2);
            if (start) poked = 1'b1;
            if (tx_sent) begin
                seen = 1'b1;
                break;
            end
        end
        chk("frame_done_in_budget", 64'(seen), 64'd1);
        if (falls.size() > 0) chk("sent_after_last_fall", 64'(ncyc - falls[falls.size()-1]), 64'd1);
        chk("busy_in_sent_cycle", 64'(busy), 64'd1);
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_after_sent", 64'(busy), 64'd0);
        chk("sent_pulse_once", 64'(sent_cnt - s0), 64'd1);
        chk("frame_len", 64'(got.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) chk("tx_byte", 64'(got[k]), 64'(exp_q[k]));
        if (start_cycs.size() > 0) chk("first_start_latency", 64'(start_cycs[0] - m), 64'(WFR + 1));
        for (int k = 1; k < start_cycs.size() && k - 1 < falls.size(); k++)
            chk("byte_gap", 64'(start_cycs[k] - falls[k-1]), 64'(IBD + 1));
        chk("disp_data", 64'(disp_data), 64'(exp_disp));
        chk("disp_en", 64'(disp_en), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_tx_sent"}, 64'(tx_sent), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_disp_data"}, 64'(disp_data), 64'd0);
        chk({tag, "_disp_en"}, 64'(disp_en), 64'd0);
    endtask

    initial begin
        int s0;
        reset = 1'b1; start = 1'b0; byte_count = 3'd0; msb_first = 1'b0; data_in = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        run_frame(32'h11223344, 0, 1'b1, 1'b0);
        run_frame(32'h11223344, 2, 1'b0, 1'b0);
        run_frame(32'h11223344, 0, 1'b1, 1'b1);
        run_frame(32'hA5C3_0F81, 1, 1'b1, 1'b0);

        // Reset while the UART is still shifting the second byte.
        wait_uart_idle();
        @(negedge clk); #1;
        data_in = 32'h11223344; byte_count = 3'd0; msb_first = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 500 && start_cycs.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        chk("second_byte_reached", 64'(start_cycs.size() >= 2), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        s0 = sent_cnt;
        reset = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("no_sent_after_reset", 64'(sent_cnt - s0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);
        run_frame(32'h11223344, 0, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_frame($urandom, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multibyte_tx_ctrl.md
# multibyte_tx_ctrl

Parametrised result transmitter that latches an N-byte result word and sends it over the UART transmitter one byte at a time. It adds runtime byte count, selectable byte order and a latched display copy. It sits between the processing unit's result bus and the UART TX core, and replaces the fixed 4-byte transmit controller plus byte handler. It also feeds the 7-segment driver through `disp_data`/`disp_en`.

## Interface
- `NUM_BYTES`, 4: maximum bytes per result; `data_in` width is `8*NUM_BYTES`; legal range 1..16.
- `INTER_BYTE_DELAY`, 1_000_000: idle cycles between the end of one byte (tx_busy falls) and the next `tx_start`.
- `WAIT_FOR_REGISTER_DELAY`, 100: cycles between latching `data_in` and the first `tx_start`; 0 is treated as 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request to send; sampled only in IDLE.
- `byte_count` in `$clog2(NUM_BYTES+1)`: bytes to send; 0 or >NUM_BYTES means NUM_BYTES.
- `msb_first` in 1: 1 sends the most significant byte first, 0 sends the least significant byte first.
- `data_in` in `8*NUM_BYTES`: result word, byte 0 = bits [7:0].
- `tx_busy` in 1: UART TX busy flag.
- `tx_start` out 1: one-cycle send strobe to the UART.
- `tx_data` out 8: byte for the UART; valid from the `tx_start` cycle until the next `tx_start`.
- `tx_sent` out 1: one-cycle pulse when the whole frame is complete.
- `busy` out 1: high from the cycle after `start` is accepted through the `tx_sent` cycle.
- `disp_data` out `8*NUM_BYTES`: copy of the latched word, with unsent bytes zeroed.
- `disp_en` out 1: high from latch until the next accepted `start`.

## Operation
- States: IDLE, LATCH, START, WAIT_BUSY, WAIT_DONE, GAP, (CHECK), DONE.
- IDLE with `start`=1: register `data_in`, the effective count N, `msb_first` and `disp_data`; set `disp_en`=1; go to LATCH.
- LATCH: count WAIT_FOR_REGISTER_DELAY cycles, then go to START.
- START: `tx_start`=1 for one cycle; `tx_data` is loaded on the same edge with byte index i (i = N-1-k if msb_first, else k, where k is the send ordinal). Go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: wait for `tx_busy`=0. If k = N-1, go to DONE (or CHECK when checksum is enabled); otherwise k++ and go to GAP.
- GAP: count INTER_BYTE_DELAY cycles, then go to START.
- DONE: `tx_sent`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, not queued. `data_in` changes after the latch have no effect.
- `tx_busy` already high in START: WAIT_BUSY exits on the next cycle. This case is legal.
- Reset mid-frame: all state clears immediately. No partial `tx_sent` is produced. The UART may still finish the byte in flight.
- Reset values: `tx_start`=0, `tx_data`=0, `tx_sent`=0, `busy`=0, `disp_data`=0, `disp_en`=0, state IDLE, counters 0.

## Timing
- `start` is sampled at edge E0. `busy` is high after E0.
- First `tx_start` is high in the cycle after E0 + WAIT_FOR_REGISTER_DELAY edges.
- Byte-to-byte spacing: fall of `tx_busy` + INTER_BYTE_DELAY + 1 cycles to the next `tx_start`.
- `tx_sent` is high in the cycle after the edge that sees `tx_busy`=0 for the last byte. `busy` falls on the following edge.
- Delay counters are `$clog2(max delay+1)` bits wide and saturate-free: they are reloaded on each state entry.

## Configuration
- `MULTIBYTE_TX_CTRL_CHECKSUM_EN` defined: after the last data byte, add GAP, then a CHECK state.
  - CHECK sends one extra byte equal to the XOR of all N sent bytes, with the same start/busy handshake, then goes to DONE.
  - Frame length becomes N+1.
  - `disp_data` is unaffected.
- Not defined: no CHECK state, no XOR register; frame length is N.

## Structure
- Package `multibyte_tx_pkg`:
  - `state_t` enum;
  - `BYTE_W`=8;
  - function `eff_count()` implementing the clamp of `byte_count`.
- Sub-module `delay_counter`:
  - load/expire countdown;
  - parameter `MAX`;
  - inputs `load`, `value`; output `expired`;
  - shared by LATCH and GAP via a state-selected load value.

## Test plan
Use NUM_BYTES=4, INTER_BYTE_DELAY=5, WAIT_FOR_REGISTER_DELAY=3, and a UART model with 10-cycle busy.
- `data_in`=0x11223344, `byte_count`=0, `msb_first`=1, `start` pulse -> `tx_data` 0x11,0x22,0x33,0x44; first `tx_start` 4 cycles after `start`; single `tx_sent`; `disp_data`=0x11223344.
- Same data, `msb_first`=0, `byte_count`=2 -> 0x44,0x33 only; `disp_data`=0x00003344.
- `start` pulsed during the second byte -> ignored; exactly 4 bytes and 1 `tx_sent`; a new `start` after `tx_sent` is accepted.
- Gap check -> each `tx_start` follows the previous `tx_busy` fall by exactly 6 cycles.
- `reset` asserted in WAIT_DONE of byte 1 -> all outputs 0 the same cycle; no `tx_sent`; next frame starts cleanly at byte 0.
- With `MULTIBYTE_TX_CTRL_CHECKSUM_EN` and 0x11223344 -> 5th byte 0x44 (0x11^0x22^0x33^0x44), then `tx_sent`.
